// File: rtl/fifo_pkt_drain.sv
// fifo_pkt_drain: pops a synchronous FIFO and re-presents its entries as a
// valid/ready stream through a registered 2-entry skid buffer.
// Beats are grouped into PKT_LEN-beat packets; the final beat carries out_last.
// When en drops mid-packet, the block keeps popping until the packet completes.
// Optional feature macro: FIFO_PKT_CNT_EN adds a 16-bit completed-packet counter.
module fifo_pkt_drain #(
    parameter int DW      = 24,
    parameter int PKT_LEN = 16,
    parameter int BW      = $clog2(PKT_LEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          fifo_vld,
    input  logic [DW-1:0] fifo_data,
    output logic          fifo_pop,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy
`ifdef FIFO_PKT_CNT_EN
    ,
    output logic [15:0]   pkt_count
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic [BW-1:0] in_beat_r;
    logic [1:0]    occ_r;
    logic [DW-1:0] head_data_r;
    logic          head_last_r;
    logic [DW-1:0] tail_data_r;
    logic          tail_last_r;
    logic          pop_s;
    logic          hs_s;
    logic          pop_last_s;

    // The pop decision looks only at registers, en and fifo_vld, never at out_ready.
    always_comb begin
        pop_s      = 1'b0;
        hs_s       = 1'b0;
        pop_last_s = 1'b0;
        if (fifo_vld && (occ_r != 2'd2) &&
            (((state_r == ACTIVE) && en) || (state_r == DRAIN))) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        if ((occ_r != 2'd0) && out_ready) begin
            hs_s = 1'b1;
        end else begin
            hs_s = 1'b0;
        end
        if (in_beat_r == BW'(PKT_LEN - 1)) begin
            pop_last_s = 1'b1;
        end else begin
            pop_last_s = 1'b0;
        end
    end

    // Next-state logic: stopping is only allowed on a packet boundary.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (en) begin
                    state_next_s = ACTIVE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACTIVE: begin
                if (en) begin
                    state_next_s = ACTIVE;
                end else if (in_beat_r == {BW{1'b0}}) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            DRAIN: begin
                if (pop_s && pop_last_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register and pop-side beat counter (wraps at PKT_LEN-1).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            in_beat_r <= {BW{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (pop_s) begin
                if (pop_last_s) begin
                    in_beat_r <= {BW{1'b0}};
                end else begin
                    in_beat_r <= in_beat_r + BW'(1);
                end
            end
        end
    end

    // Skid buffer: head entry drives the stream, tail holds the overflow beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_r       <= 2'd0;
            head_data_r <= {DW{1'b0}};
            head_last_r <= 1'b0;
            tail_data_r <= {DW{1'b0}};
            tail_last_r <= 1'b0;
        end else begin
            case (occ_r)
                2'd0: begin
                    if (pop_s) begin
                        head_data_r <= fifo_data;
                        head_last_r <= pop_last_s;
                        occ_r       <= 2'd1;
                    end
                end
                2'd1: begin
                    if (pop_s && hs_s) begin
                        head_data_r <= fifo_data;
                        head_last_r <= pop_last_s;
                    end else if (pop_s) begin
                        tail_data_r <= fifo_data;
                        tail_last_r <= pop_last_s;
                        occ_r       <= 2'd2;
                    end else if (hs_s) begin
                        occ_r <= 2'd0;
                    end
                end
                2'd2: begin
                    // No pop is possible while full; only a handshake moves data.
                    if (hs_s) begin
                        head_data_r <= tail_data_r;
                        head_last_r <= tail_last_r;
                        occ_r       <= 2'd1;
                    end
                end
                default: begin
                    occ_r <= 2'd0;
                end
            endcase
        end
    end

`ifdef FIFO_PKT_CNT_EN
    logic [15:0] pkt_count_r;

    // Completed-packet counter, bumped when the last beat of a packet leaves.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_count_r <= 16'd0;
        end else if (hs_s && head_last_r) begin
            pkt_count_r <= pkt_count_r + 16'd1;
        end
    end

    assign pkt_count = pkt_count_r;
`endif

    assign fifo_pop  = pop_s;
    assign out_valid = (occ_r != 2'd0);
    assign out_data  = head_data_r;
    assign out_last  = head_last_r;
    assign busy      = (state_r != IDLE) || (occ_r != 2'd0);

endmodule

// File: tb/tb_fifo_pkt_drain.sv
// Self-checking bench for fifo_pkt_drain (PKT_LEN=4). The upstream FIFO is a
// queue owned by the bench; expected stream beats and pop permission come from
// a packet-level model (pop count modulo PKT_LEN, outstanding beat count).
module tb_fifo_pkt_drain;
    localparam int DW = 24;
    localparam int L  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          fifo_vld;
    logic [DW-1:0] fifo_data;
    logic          fifo_pop;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
`ifdef FIFO_PKT_CNT_EN
    logic [15:0]   pkt_count;
`endif

    fifo_pkt_drain #(.DW(DW), .PKT_LEN(L)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .fifo_vld(fifo_vld),
        .fifo_data(fifo_data), .fifo_pop(fifo_pop), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy)
`ifdef FIFO_PKT_CNT_EN
        , .pkt_count(pkt_count)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] src_q[$];
    logic [DW:0]   exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  pops = 0;
    int  hss = 0;
    int  popcnt = 0;
    int  outst = 0;
    int  pkts_m = 0;
    bit  active_m = 1'b0;
    bit  drain_m = 1'b0;
    bit  rst_prev = 1'b1;
    int  p0;
    int  guard;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_src();
        fifo_vld  = (src_q.size() != 0);
        fifo_data = (src_q.size() != 0) ? src_q[0] : '0;
    endtask

    task automatic cycle();
        bit          exp_pop;
        bit          hs;
        bit          p;
        bit          mid_after;
        bit          new_active;
        bit          new_drain;
        logic [DW:0] e;
        hs = 1'b0;
        p  = 1'b0;
        @(negedge clk);
        if (!rst_n) begin
            if (!rst_prev) begin
                check("rst_fifo_pop", fifo_pop, 0);
                check("rst_out_valid", out_valid, 0);
                check("rst_out_data", out_data, 0);
                check("rst_out_last", out_last, 0);
                check("rst_busy", busy, 0);
`ifdef FIFO_PKT_CNT_EN
                check("rst_pkt_count", pkt_count, 0);
`endif
            end
        end else begin
            exp_pop = fifo_vld && (outst < 2) && ((active_m && en) || drain_m);
            check("fifo_pop", fifo_pop, exp_pop);
            check("out_valid", out_valid, (outst != 0));
            check("busy", busy, active_m || drain_m || (outst != 0));
`ifdef FIFO_PKT_CNT_EN
            check("pkt_count", pkt_count, pkts_m & 16'hFFFF);
`endif
            hs = out_valid && out_ready;
            p  = fifo_pop && fifo_vld;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", out_valid, 0);
                end else begin
                    check("out_data", out_data, exp_q[0][DW-1:0]);
                    check("out_last", out_last, exp_q[0][DW]);
                end
            end
        end
        @(posedge clk);
        rst_prev = rst_n;
        if (!rst_n) begin
            active_m = 1'b0;
            drain_m  = 1'b0;
            popcnt   = 0;
            outst    = 0;
            pkts_m   = 0;
            exp_q.delete();
        end else begin
            if (hs && exp_q.size() != 0) begin
                if (exp_q[0][DW]) pkts_m++;
                void'(exp_q.pop_front());
                outst--;
                hss++;
            end
            if (p && src_q.size() != 0) begin
                e = {((popcnt % L) == (L - 1)), src_q[0]};
                exp_q.push_back(e);
                void'(src_q.pop_front());
                popcnt++;
                outst++;
                pops++;
            end
            mid_after  = (popcnt % L) != 0;
            new_drain  = mid_after && (drain_m || (active_m && !en));
            new_active = en && !drain_m;
            drain_m    = new_drain;
            active_m   = new_active;
        end
        #1;
        drive_src();
    endtask

    initial begin
        // Reset with en=1 and a non-empty FIFO.
        rst_n = 1'b0;
        en = 1'b1;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) src_q.push_back(DW'(i));
        drive_src();
        repeat (3) cycle();
        rst_n = 1'b1;
        cycle();
        check("no_pop_first_cycle", pops, 0);
        cycle();
        check("pop_second_cycle", pops, 1);
        // Back-to-back stream: 8 beats in 8 consecutive cycles.
        repeat (8) cycle();
        check("stream_count", hss, 8);

        // Backpressure mid-stream.
        for (int i = 9; i <= 24; i++) src_q.push_back(DW'(i));
        drive_src();
        repeat (2) cycle();
        out_ready = 1'b0;
        p0 = pops;
        repeat (6) cycle();
        check("bp_pops_le2", ((pops - p0) <= 2), 1);
        check("bp_buffered", outst, 2);
        check("bp_pop_low", fifo_pop, 0);
        out_ready = 1'b1;
        guard = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && guard < 60) begin
            cycle();
            guard++;
        end
        check("bp_total", hss, 24);

        // Mid-packet stop after 2 pops of a packet.
        for (int i = 0; i < 32; i++) src_q.push_back(DW'(32'h100 + i));
        drive_src();
        guard = 0;
        while ((popcnt % L) != 2 && guard < 20) begin
            cycle();
            guard++;
        end
        en = 1'b0;
        p0 = pops;
        repeat (10) cycle();
        check("drain_pops", pops - p0, 2);
        check("drain_boundary", popcnt % L, 0);

        // Boundary stop: no extra pops, then resume at beat 0.
        en = 1'b1;
        p0 = pops;
        guard = 0;
        while (!((popcnt % L) == 0 && pops > p0) && guard < 20) begin
            cycle();
            guard++;
        end
        en = 1'b0;
        p0 = pops;
        repeat (5) cycle();
        check("boundary_no_pop", pops - p0, 0);
        en = 1'b1;
        repeat (8) cycle();

        // Randomized traffic with one mid-operation reset.
        for (int n = 0; n < 3000; n++) begin
            if ((n / 150) % 2 == 0) en = ($urandom_range(0, 7) != 0);
            else en = ($urandom_range(0, 1) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if (src_q.size() < 6 && $urandom_range(0, 2) != 0) begin
                src_q.push_back(DW'($urandom));
                drive_src();
            end
            if (n == 1500) begin
                rst_n = 1'b0;
                cycle();
                cycle();
                rst_n = 1'b1;
            end
            cycle();
        end

        // Finish any open packet and empty the buffer.
        en = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while ((active_m || drain_m || outst != 0) && guard < 200) begin
            if (src_q.size() == 0) begin
                src_q.push_back(DW'($urandom));
                drive_src();
            end
            cycle();
            guard++;
        end
        check("final_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
